data_connection_block_cfg: RTL and testbench

//  Unidirectional-fabric connection block with an integrated, double-buffered configuration loader.
//  - Taps logic-block inputs from the north/south routing tracks.
//  - Drives routing tracks from logic-block outputs, or passes the opposite track through.
//  - Config arrives as CFG_W-bit words over a valid/ready stream into a shadow register.
//  - An explicit commit copies shadow to active, so routing never glitches mid-load.

---
 rtl/data_connection_block_cfg_pkg.sv | 44 ++++
 rtl/data_connection_block_cfg_if.sv | 22 ++
 rtl/data_connection_block_cfg_loader.sv | 78 +++++++
 rtl/data_connection_block_cfg.sv | 99 +++++++++
 tb/tb_data_connection_block_cfg.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_connection_block_cfg_pkg.sv
// Shared types and layout helpers for the data connection block.
package dcb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FULL,
    COMMIT
  } ld_state_e;

  function automatic int sel_in_f(int w, int ww);
    return $clog2(2 * w / ww);
  endfunction

  function automatic int sel_out_f(int dout);
    return $clog2(dout + 1);
  endfunction

  function automatic int cfg_bits_f(int w, int ww,
                                    int din, int dout);
    return sel_in_f(w, ww) * din * ww
         + sel_out_f(dout) * 2 * w;
  endfunction

  function automatic int cfg_words_f(int bits, int cw);
    return (bits + cw - 1) / cw;
  endfunction

  function automatic int in_off_f(int i, int j,
                                  int ww, int sel_in);
    return (i * ww + j) * sel_in;
  endfunction

  function automatic int n_off_f(int t, int base,
                                 int sel_out);
    return base + 2 * t * sel_out;
  endfunction

  function automatic int s_off_f(int t, int base,
                                 int sel_out);
    return base + (2 * t + 1) * sel_out;
  endfunction

endpackage

// File: rtl/data_connection_block_cfg_if.sv
// Config stream: word handshake, commit request and loader status.
interface dcb_cfg_if #(
  parameter int CFG_W = 8
);
  logic             valid;
  logic             ready;
  logic [CFG_W-1:0] data;
  logic             commit;
  logic             full;
  logic             done;
  logic             err;

  modport master (
    output valid, data, commit,
    input  ready, full, done, err
  );

  modport slave (
    input  valid, data, commit,
    output ready, full, done, err
  );
endinterface

// File: rtl/data_connection_block_cfg_loader.sv
// Double-buffered config loader: shift into shadow, commit to active.
module dcb_cfg_loader
  import dcb_pkg::*;
#(
  parameter int CFG_W     = 8,
  parameter int CFG_BITS  = 112,
  parameter int CFG_WORDS = 14
) (
  input  logic                clk,
  input  logic                rst,
  dcb_cfg_if.slave            cfg,
  output logic [CFG_BITS-1:0] active_o
);

  localparam int SH = CFG_WORDS * CFG_W;
  localparam int CW = $clog2(CFG_WORDS + 1);
  localparam logic [CW-1:0] LAST = CW'(CFG_WORDS);

  ld_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_nx;
  logic [SH-1:0]     sh_q;
  logic [CFG_BITS-1:0] act_q;
  logic              err_q;
  logic              rdy;
  logic              acc;

  assign rdy    = (state_q == IDLE) || (state_q == SHIFT);
  assign acc    = cfg.valid && rdy;
  assign cnt_nx = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, SHIFT:
        if (acc) state_d = (cnt_nx == LAST) ? FULL : SHIFT;
      FULL:
        if (cfg.commit) state_d = COMMIT;
      COMMIT:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg.ready = rdy;
    cfg.full  = (state_q == FULL);
    cfg.done  = (state_q == COMMIT);
    cfg.err   = err_q;
  end

  // Shadow shifts right so the first word ends up in the low bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sh_q  <= '0;
      act_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= cfg.commit && (state_q != FULL);
      if (state_q == COMMIT) begin
        cnt_q <= '0;
        act_q <= sh_q[CFG_BITS-1:0];
      end else if (acc) begin
        cnt_q <= cnt_nx;
        sh_q  <= {cfg.data, sh_q[SH-1:CFG_W]};
      end
    end
  end

  assign active_o = act_q;

endmodule

// File: rtl/data_connection_block_cfg.sv
// Connection block routing muxes driven by the committed config.
// Define DCB_REG_OUT_EN to register the routing outputs.
module data_connection_block_cfg
  import dcb_pkg::*;
#(
  parameter int W       = 16,
  parameter int WW      = 4,
  parameter int DATAIN  = 4,
  parameter int DATAOUT = 3,
  parameter int CFG_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W-1:0]          north_in,
  input  logic [W-1:0]          south_in,
  output logic [W-1:0]          north_out,
  output logic [W-1:0]          south_out,
  output logic [WW*DATAIN-1:0]  data_input,
  input  logic [WW*DATAOUT-1:0] data_output,
  dcb_cfg_if.slave              cfg
);

  localparam int SEL_IN    = sel_in_f(W, WW);
  localparam int SEL_OUT   = sel_out_f(DATAOUT);
  localparam int CFG_BITS  = cfg_bits_f(W, WW, DATAIN, DATAOUT);
  localparam int CFG_WORDS = cfg_words_f(CFG_BITS, CFG_W);
  localparam int NSRC      = 2 * W / WW;
  localparam int OBASE     = SEL_IN * DATAIN * WW;

  logic [CFG_BITS-1:0]   act;
  logic [W-1:0]          no_c, so_c;
  logic [WW*DATAIN-1:0]  din_c;

  dcb_cfg_loader #(
    .CFG_W     (CFG_W),
    .CFG_BITS  (CFG_BITS),
    .CFG_WORDS (CFG_WORDS)
  ) u_loader (
    .clk      (clk),
    .rst      (rst),
    .cfg      (cfg),
    .active_o (act)
  );

  // Even selector values tap north, odd tap south.
  always_comb begin
    din_c = '0;
    no_c  = south_in;
    so_c  = north_in;
    for (int i = 0; i < DATAIN; i++) begin
      for (int j = 0; j < WW; j++) begin
        for (int k = 0; k < NSRC; k++) begin
          if (act[in_off_f(i, j, WW, SEL_IN) +: SEL_IN]
              == SEL_IN'(k)) begin
            din_c[i*WW+j] = (k % 2 == 1)
              ? south_in[(k/2)*WW+j]
              : north_in[(k/2)*WW+j];
          end
        end
      end
    end
    for (int t = 0; t < W; t++) begin
      for (int g = 0; g < DATAOUT; g++) begin
        if (act[n_off_f(t, OBASE, SEL_OUT) +: SEL_OUT]
            == SEL_OUT'(g + 1))
          no_c[t] = data_output[g*WW + t%WW];
        if (act[s_off_f(t, OBASE, SEL_OUT) +: SEL_OUT]
            == SEL_OUT'(g + 1))
          so_c[t] = data_output[g*WW + t%WW];
      end
    end
  end

`ifdef DCB_REG_OUT_EN
  logic [W-1:0]         no_q, so_q;
  logic [WW*DATAIN-1:0] din_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      no_q  <= '0;
      so_q  <= '0;
      din_q <= '0;
    end else begin
      no_q  <= no_c;
      so_q  <= so_c;
      din_q <= din_c;
    end
  end

  assign north_out  = no_q;
  assign south_out  = so_q;
  assign data_input = din_q;
`else
  assign north_out  = no_c;
  assign south_out  = so_c;
  assign data_input = din_c;
`endif

endmodule

// File: tb/tb_data_connection_block_cfg.sv
// Directed bench for data_connection_block_cfg, both output modes.
module tb_data_connection_block_cfg;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  ni, si, no, so, din;
  logic [11:0]  dout;
  logic [111:0] vin, va, vz;
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  dcb_cfg_if #(.CFG_W(8)) cfg ();

  data_connection_block_cfg dut (
    .clk         (clk),
    .rst         (rst),
    .north_in    (ni),
    .south_in    (si),
    .north_out   (no),
    .south_out   (so),
    .data_input  (din),
    .data_output (dout),
    .cfg         (cfg)
  );

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic load(input logic [111:0] v,
                      input int first, input int n);
    for (int w = first; w < first + n; w++) begin
      cfg.data  = v[w*8 +: 8];
      cfg.valid = 1'b1;
      @(negedge clk);
    end
    cfg.valid = 1'b0;
  endtask

  task automatic commit();
    cfg.commit = 1'b1;
    @(negedge clk);
    cfg.commit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cfg.valid = 1'b0; cfg.commit = 1'b0; cfg.data = 8'h00;
    ni = 16'hA5C3; si = 16'h3C5A; dout = 12'h000;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cfg.ready, cfg.full, cfg.done, cfg.err} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 1000",
               {cfg.ready, cfg.full, cfg.done, cfg.err});
    end
    rst = 1'b1;
    settle();
    n_cmp++;
    if (no !== 16'h3C5A || so !== 16'hA5C3) begin
      n_bad++;
      $display("FAIL reset_pass: got no=%h so=%h want 3c5a a5c3", no, so);
    end
    n_cmp++;
    if (din !== 16'h3333) begin
      n_bad++;
      $display("FAIL reset_din: got %h want 3333", din);
    end
  endtask

  task automatic test_load_commit();
    load(vin, 0, 14);
    n_cmp++;
    if (cfg.full !== 1'b1 || cfg.ready !== 1'b0) begin
      n_bad++;
      $display("FAIL lc_full: got full=%b ready=%b want 1 0",
               cfg.full, cfg.ready);
    end
    commit();
    n_cmp++;
    if (cfg.done !== 1'b1 || din !== 16'h3333 || no !== 16'h3C5A) begin
      n_bad++;
      $display("FAIL lc_pre: got done=%b din=%h no=%h want 1 3333 3c5a",
               cfg.done, din, no);
    end
    @(negedge clk);
    n_cmp++;
    if (cfg.done !== 1'b0 || cfg.ready !== 1'b1 || cfg.full !== 1'b0) begin
      n_bad++;
      $display("FAIL lc_after: got done=%b ready=%b full=%b want 0 1 0",
               cfg.done, cfg.ready, cfg.full);
    end
    @(negedge clk);
    n_cmp++;
    if (din !== 16'h5555 || no !== 16'h3C5A || so !== 16'hA5C3) begin
      n_bad++;
      $display("FAIL lc_route: got din=%h no=%h so=%h want 5555 3c5a a5c3",
               din, no, so);
    end
  endtask

  task automatic test_out_sel();
    load(va, 0, 14);
    commit();
    @(negedge clk);
    si = 16'hFFFF; dout = 12'h020;
    settle();
    n_cmp++;
    if (no !== 16'hFFFF || so !== 16'hA5C3 || din !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL os_ones: got no=%h so=%h din=%h want ffff a5c3 ffff",
               no, so, din);
    end
    si = 16'h0000; dout = 12'h420;
    settle();
    n_cmp++;
    if (no !== 16'h0020 || so !== 16'hA5C7 || din !== 16'h0000) begin
      n_bad++;
      $display("FAIL os_zero: got no=%h so=%h din=%h want 0020 a5c7 0000",
               no, so, din);
    end
    si = 16'h3C5A; dout = 12'h020;
    settle();
    n_cmp++;
    if (no !== 16'h3C7A || so !== 16'hA5C3 || din !== 16'h5555) begin
      n_bad++;
      $display("FAIL os_mix: got no=%h so=%h din=%h want 3c7a a5c3 5555",
               no, so, din);
    end
  endtask

  task automatic test_mid_reset();
    load(va, 0, 7);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cfg.ready !== 1'b1 || cfg.full !== 1'b0) begin
      n_bad++;
      $display("FAIL mr_flags: got ready=%b full=%b want 1 0",
               cfg.ready, cfg.full);
    end
    rst = 1'b1;
    settle();
    n_cmp++;
    if (no !== 16'h3C5A || din !== 16'h3333) begin
      n_bad++;
      $display("FAIL mr_pass: got no=%h din=%h want 3c5a 3333", no, din);
    end
    load(va, 0, 13);
    n_cmp++;
    if (cfg.full !== 1'b0) begin
      n_bad++;
      $display("FAIL mr_13w: got full=%b want 0", cfg.full);
    end
    load(va, 13, 1);
    n_cmp++;
    if (cfg.full !== 1'b1) begin
      n_bad++;
      $display("FAIL mr_14w: got full=%b want 1", cfg.full);
    end
    commit();
    n_cmp++;
    if (cfg.done !== 1'b1) begin
      n_bad++;
      $display("FAIL mr_done: got %b want 1", cfg.done);
    end
    settle();
    n_cmp++;
    if (no !== 16'h3C7A || din !== 16'h5555) begin
      n_bad++;
      $display("FAIL mr_route: got no=%h din=%h want 3c7a 5555", no, din);
    end
  endtask

  task automatic test_err();
    load(vz, 0, 5);
    commit();
    n_cmp++;
    if (cfg.err !== 1'b1 || cfg.done !== 1'b0) begin
      n_bad++;
      $display("FAIL er_pulse: got err=%b done=%b want 1 0",
               cfg.err, cfg.done);
    end
    @(negedge clk);
    n_cmp++;
    if (cfg.err !== 1'b0 || cfg.ready !== 1'b1 || cfg.full !== 1'b0) begin
      n_bad++;
      $display("FAIL er_after: got err=%b ready=%b full=%b want 0 1 0",
               cfg.err, cfg.ready, cfg.full);
    end
    settle();
    n_cmp++;
    if (no !== 16'h3C7A || din !== 16'h5555) begin
      n_bad++;
      $display("FAIL er_route: got no=%h din=%h want 3c7a 5555", no, din);
    end
    load(vz, 5, 9);
    n_cmp++;
    if (cfg.full !== 1'b1) begin
      n_bad++;
      $display("FAIL er_full: got %b want 1", cfg.full);
    end
    commit();
    settle();
    n_cmp++;
    if (no !== 16'h3C5A || din !== 16'h3333 || so !== 16'hA5C3) begin
      n_bad++;
      $display("FAIL er_zero: got no=%h din=%h so=%h want 3c5a 3333 a5c3",
               no, din, so);
    end
  endtask

  task automatic test_full_hold();
    load(va, 0, 14);
    cfg.valid = 1'b1;
    cfg.data  = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (cfg.ready !== 1'b0 || cfg.full !== 1'b1) begin
        n_bad++;
        $display("FAIL fh_hold%0d: got ready=%b full=%b want 0 1",
                 c, cfg.ready, cfg.full);
      end
    end
    commit();
    cfg.valid = 1'b0;
    n_cmp++;
    if (cfg.done !== 1'b1) begin
      n_bad++;
      $display("FAIL fh_done: got %b want 1", cfg.done);
    end
    settle();
    n_cmp++;
    if (no !== 16'h3C7A || din !== 16'h5555 || so !== 16'hA5C3) begin
      n_bad++;
      $display("FAIL fh_route: got no=%h din=%h so=%h want 3c7a 5555 a5c3",
               no, din, so);
    end
    n_cmp++;
    if (cfg.ready !== 1'b1 || cfg.full !== 1'b0) begin
      n_bad++;
      $display("FAIL fh_idle: got ready=%b full=%b want 1 0",
               cfg.ready, cfg.full);
    end
  endtask

  initial begin
    vin = '0;
    for (int f = 0; f < 16; f++) vin[f*3 +: 3] = 3'd3;
    va = vin;
    va[68 +: 2] = 2'd2;
    va[58 +: 2] = 2'd3;
    vz = '0;
    test_reset();
    test_load_commit();
    test_out_sel();
    test_mid_reset();
    test_err();
    test_full_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
